ifetch_sequencer: RTL
=====================

# ifetch_sequencer

Control sequencer for the instruction-fetch stage. It takes a byte stream from the debug link, loads a program into instruction memory one byte at a time, then runs the fetch stage in either continuous or single-step mode until the pipeline reports a halt. It drives every enable, reset and write strobe the fetch stage exposes, and sits between the debug receiver and the fetch stage.

## Interface
- INSTMEM_SIZE, 8, width of the instruction-memory byte address
- MEM_SIZE, 8, width of the instruction-memory write data
- HALT_BYTE, 8'hFF, byte value; four of these in one aligned word mark the HALT instruction
- CNT_SIZE, 32, width of the executed-cycle counter

Ports:
- i_clock  in  1  system clock, rising edge
- i_reset  in  1  reset, asynchronous, active-high
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe qualifying i_rx_data
- i_halt  in  1  pipeline has retired HALT (level)
- o_instrmem_en  out  1  instruction memory enable
- o_write_en  out  1  instruction memory write strobe
- o_write_data  out  MEM_SIZE  byte to write
- o_write_addr  out  INSTMEM_SIZE  byte address to write
- o_read_en  out  1  instruction memory read enable
- o_pc_en  out  1  PC advance enable
- o_pc_reset  out  1  holds PC at 0
- o_state  out  3  current state encoding
- o_load_full  out  1  load stopped because memory filled
- o_done  out  1  program finished
- o_cycle_count  out  CNT_SIZE  cycles with o_pc_en high since last load

## Operation
- Encodings: IDLE=0, LOAD=1, READY=2, RUN=3, STEP=4, DONE=5.
- Commands are bytes accepted on i_rx_valid. 'L'=8'h4C, 'C'=8'h43, 'S'=8'h53, 'N'=8'h4E, 'R'=8'h52. Any other byte is ignored in every state except LOAD.
- IDLE: o_pc_reset=1. 'L' moves to LOAD and clears the address, o_load_full and o_cycle_count.
- LOAD:
  - Every valid byte is data and is written at the current address; the address then increments.
  - A 2-bit byte-lane counter tracks word alignment. If the four bytes of one aligned word all equal HALT_BYTE, the FSM goes to READY after that 4th write.
  - If the byte written is at address 2^INSTMEM_SIZE-1 and no HALT was detected, the FSM goes to READY with o_load_full=1. The address is not wrapped.
  - o_pc_reset=1 throughout.
- READY: o_pc_reset=1. 'C' moves to RUN, 'S' moves to STEP, 'R' moves to IDLE.
- RUN: o_pc_en=1 and o_read_en=1 every cycle. Received bytes are ignored. i_halt moves to DONE.
- STEP: o_read_en=1. Each 'N' raises o_pc_en for exactly one cycle. i_halt moves to DONE. 'R' moves to IDLE.
- DONE: o_done=1, o_pc_en=0, PC is held (o_pc_reset=0). 'R' moves to IDLE.
- o_instrmem_en=1 in every state except IDLE.
- o_cycle_count increments on every cycle in which o_pc_en=1. It saturates at its all-ones value.

## Timing
- All outputs are registered.
- Reset values: state IDLE, o_pc_reset=1, and every other output 0 (address 0, lane 0, count 0).
- Write path: a byte accepted at edge N produces o_write_en=1 with its data and address during the cycle after edge N (one cycle wide). The address increments at the same edge.
- The transition to READY (HALT or full) takes effect at the same edge as the final write. o_write_en for that byte is still issued.
- Step: 'N' accepted at edge N gives o_pc_en=1 for the cycle after edge N only. Back-to-back 'N' strobes give back-to-back pulses.
- Run: the edge that enters RUN raises o_pc_en. i_halt sampled high at edge N drops o_pc_en and sets o_done from edge N.
- Simultaneous events:
  - i_halt and 'N' sampled at the same edge: halt wins and no pulse is issued.
  - 'R' and i_halt sampled together in STEP: 'R' wins and the FSM goes to IDLE.
- A second command byte that arrives during a transition is evaluated in the new state on its own edge. Only one byte is accepted per cycle.
- An asynchronous i_reset at any point, including mid-LOAD or mid-RUN, forces the reset values immediately. No partial write strobe survives.

## Test plan
- Reset, then 'L', then bytes 01 02 03 04 FF FF FF FF -> 8 write strobes to addresses 0..7 carrying those data; state READY after the 8th write; o_load_full=0.
- Load with INSTMEM_SIZE=4 and 16 non-FF bytes -> writes at addresses 0..15, then READY with o_load_full=1; a 17th byte causes no write.
- Misaligned FF run: 'L', 00 FF FF FF FF 00 00 00 FF FF FF FF -> no early stop; READY only after the 12th byte.
- 'C' after load, i_halt raised 10 cycles later -> o_pc_en high for exactly 10 cycles, o_cycle_count=10, o_done=1, PC held.
- 'S', then three 'N' strobes with gaps, then 'N' together with i_halt -> three single-cycle o_pc_en pulses, count=3, DONE with no 4th pulse.
- i_reset asserted mid-LOAD at address 5, released, then 'R' and 'X' bytes -> immediate IDLE, o_pc_reset=1, no writes, state stays IDLE.

Source files
------------

// File: rtl/ifetch_sequencer_if.sv
// rtl/ifetch_sequencer_if.sv - debug-link, fetch-stage control and status signals of the fetch sequencer
interface ifetch_sequencer_if #(
    parameter int INSTMEM_SIZE = 8,
    parameter int MEM_SIZE     = 8,
    parameter int CNT_SIZE     = 32
);
    logic [7:0]              i_rx_data;
    logic                    i_rx_valid;
    logic                    i_halt;
    logic                    o_instrmem_en;
    logic                    o_write_en;
    logic [MEM_SIZE-1:0]     o_write_data;
    logic [INSTMEM_SIZE-1:0] o_write_addr;
    logic                    o_read_en;
    logic                    o_pc_en;
    logic                    o_pc_reset;
    logic [2:0]              o_state;
    logic                    o_load_full;
    logic                    o_done;
    logic [CNT_SIZE-1:0]     o_cycle_count;

    modport master (
        input  i_rx_data, i_rx_valid, i_halt,
        output o_instrmem_en, o_write_en, o_write_data, o_write_addr, o_read_en,
               o_pc_en, o_pc_reset, o_state, o_load_full, o_done, o_cycle_count
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_halt,
        input  o_instrmem_en, o_write_en, o_write_data, o_write_addr, o_read_en,
               o_pc_en, o_pc_reset, o_state, o_load_full, o_done, o_cycle_count
    );
endinterface

// File: rtl/ifetch_sequencer.sv
// rtl/ifetch_sequencer.sv - loads a program from the debug link and runs/steps the fetch stage until halt
module ifetch_sequencer #(
    parameter int         INSTMEM_SIZE = 8,
    parameter int         MEM_SIZE     = 8,
    parameter logic [7:0] HALT_BYTE    = 8'hFF,
    parameter int         CNT_SIZE     = 32
) (
    input  logic i_clock,
    input  logic i_reset,
    ifetch_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        READY = 3'd2,
        RUN   = 3'd3,
        STEP  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] CMD_C = 8'h43;
    localparam logic [7:0] CMD_S = 8'h53;
    localparam logic [7:0] CMD_N = 8'h4E;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [INSTMEM_SIZE-1:0] ADDR_MAX = {INSTMEM_SIZE{1'b1}};
    localparam logic [CNT_SIZE-1:0]     CNT_MAX  = {CNT_SIZE{1'b1}};

    state_t                  state, state_n;
    logic [INSTMEM_SIZE-1:0] addr, addr_n;
    logic [1:0]              lane, lane_n;
    logic                    word_ff, word_ff_n;
    logic                    word_is_halt;
    logic                    write_en_n;
    logic [MEM_SIZE-1:0]     write_data_n;
    logic [INSTMEM_SIZE-1:0] write_addr_n;
    logic                    pc_en_n;
    logic                    load_full_n;
    logic [CNT_SIZE-1:0]     count_n;
    logic                    rx_valid;
    logic [7:0]              rx_data;

    assign rx_valid = bus.i_rx_valid;
    assign rx_data  = bus.i_rx_data;
    // word_ff: every byte so far in the current aligned word equals HALT_BYTE
    assign word_is_halt = word_ff && (rx_data == HALT_BYTE);

    always_comb begin
        state_n      = state;
        addr_n       = addr;
        lane_n       = lane;
        word_ff_n    = word_ff;
        write_en_n   = 1'b0;
        write_data_n = bus.o_write_data;
        write_addr_n = bus.o_write_addr;
        pc_en_n      = 1'b0;
        load_full_n  = bus.o_load_full;
        count_n      = bus.o_cycle_count;

        case (state)
            IDLE: begin
                if (rx_valid && rx_data == CMD_L) begin
                    state_n     = LOAD;
                    addr_n      = '0;
                    lane_n      = 2'd0;
                    word_ff_n   = 1'b1;
                    load_full_n = 1'b0;
                    count_n     = '0;
                end
            end
            LOAD: begin
                if (rx_valid) begin
                    write_en_n   = 1'b1;
                    write_data_n = MEM_SIZE'(rx_data);
                    write_addr_n = addr;
                    lane_n       = lane + 2'd1;
                    word_ff_n    = (lane == 2'd3) ? 1'b1 : word_is_halt;
                    if (addr != ADDR_MAX) begin
                        addr_n = addr + 1'b1;
                    end
                    if (lane == 2'd3 && word_is_halt) begin
                        state_n = READY;
                    end else if (addr == ADDR_MAX) begin
                        state_n     = READY;
                        load_full_n = 1'b1;
                    end
                end
            end
            READY: begin
                if (rx_valid && rx_data == CMD_C) begin
                    state_n = RUN;
                    pc_en_n = 1'b1;
                end else if (rx_valid && rx_data == CMD_S) begin
                    state_n = STEP;
                end else if (rx_valid && rx_data == CMD_R) begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (bus.i_halt) begin
                    state_n = DONE;
                end else begin
                    pc_en_n = 1'b1;
                end
            end
            STEP: begin
                // reset request beats halt, halt beats a step pulse
                if (rx_valid && rx_data == CMD_R) begin
                    state_n = IDLE;
                end else if (bus.i_halt) begin
                    state_n = DONE;
                end else if (rx_valid && rx_data == CMD_N) begin
                    pc_en_n = 1'b1;
                end
            end
            DONE: begin
                if (rx_valid && rx_data == CMD_R) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (pc_en_n && bus.o_cycle_count != CNT_MAX) begin
            count_n = bus.o_cycle_count + 1'b1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state             <= IDLE;
            addr              <= '0;
            lane              <= 2'd0;
            word_ff           <= 1'b1;
            bus.o_write_en    <= 1'b0;
            bus.o_write_data  <= '0;
            bus.o_write_addr  <= '0;
            bus.o_pc_en       <= 1'b0;
            bus.o_load_full   <= 1'b0;
            bus.o_cycle_count <= '0;
            bus.o_instrmem_en <= 1'b0;
            bus.o_read_en     <= 1'b0;
            bus.o_pc_reset    <= 1'b1;
            bus.o_done        <= 1'b0;
        end else begin
            state             <= state_n;
            addr              <= addr_n;
            lane              <= lane_n;
            word_ff           <= word_ff_n;
            bus.o_write_en    <= write_en_n;
            bus.o_write_data  <= write_data_n;
            bus.o_write_addr  <= write_addr_n;
            bus.o_pc_en       <= pc_en_n;
            bus.o_load_full   <= load_full_n;
            bus.o_cycle_count <= count_n;
            bus.o_instrmem_en <= (state_n != IDLE);
            bus.o_read_en     <= (state_n == RUN) || (state_n == STEP);
            bus.o_pc_reset    <= (state_n == IDLE) || (state_n == LOAD) || (state_n == READY);
            bus.o_done        <= (state_n == DONE);
        end
    end

    assign bus.o_state = state;
endmodule
